// File: rtl/sram_arbiter_rr.sv
// rtl/sram_arbiter_rr.sv - round-robin multi-channel arbiter for the async 256K x 16 SRAM
module sram_arbiter_rr #(
  parameter int NUM_CH     = 4,
  parameter int AW         = 18,
  parameter int DW         = 16,
  parameter int ACCESS_CYC = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH-1:0]    req_we,
  input  logic [NUM_CH*AW-1:0] req_addr,
  input  logic [NUM_CH*DW-1:0] req_wdata,
  input  logic [NUM_CH*2-1:0]  req_be,
  output logic [NUM_CH-1:0]    gnt,
  output logic [NUM_CH-1:0]    rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic [AW-1:0]        SRAM_ADDR,
  inout  wire  [DW-1:0]        SRAM_DQ,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_CE_N
);
  localparam int IW = $clog2(NUM_CH);
  localparam int CW = $clog2(ACCESS_CYC);

  generate
    if (ACCESS_CYC < 2) begin : g_bad_cyc
      $error("sram_arbiter_rr: ACCESS_CYC must be at least 2");
    end
    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_ch
      $error("sram_arbiter_rr: NUM_CH must be in 2..8");
    end
    if (DW != 16) begin : g_bad_dw
      $error("sram_arbiter_rr: DW must be 16 (two byte lanes)");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ch;
  logic [IW-1:0] rr_last;
  logic          we_q;
  logic [1:0]    be_q;
  logic [DW-1:0] dq_out;
  logic          dq_oe;

  logic [AW-1:0] addr_a  [NUM_CH];
  logic [DW-1:0] wdata_a [NUM_CH];
  logic [1:0]    be_a    [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*AW +: AW];
    assign wdata_a[i] = req_wdata[i*DW +: DW];
    assign be_a[i]    = req_be[i*2 +: 2];
  end

  // Rotating priority: the search starts just after the last winner.
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          win_found;
  always_comb begin
    win_idx   = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IW'((int'(rr_last) + k) % NUM_CH);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ch        <= '0;
      rr_last   <= IW'(NUM_CH - 1);
      we_q      <= 1'b0;
      be_q      <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state     <= S_ACCESS;
            busy      <= 1'b1;
            gnt       <= NUM_CH'(1) << win_idx;
            rr_last   <= win_idx;
            ch        <= win_idx;
            cnt       <= CW'(ACCESS_CYC - 1);
            we_q      <= req_we[win_idx];
            be_q      <= be_a[win_idx];
            SRAM_ADDR <= addr_a[win_idx];
            dq_out    <= wdata_a[win_idx];
            dq_oe     <= req_we[win_idx];
            SRAM_CE_N <= 1'b0;
            SRAM_UB_N <= ~be_a[win_idx][1];
            SRAM_LB_N <= ~be_a[win_idx][0];
            SRAM_WE_N <= ~req_we[win_idx];
            SRAM_OE_N <= req_we[win_idx];
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            dq_oe     <= 1'b0;
            SRAM_CE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            if (!we_q) begin
              rdata      <= SRAM_DQ & {{8{be_q[1]}}, {8{be_q[0]}}};
              rvalid[ch] <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
            // WE_N rises one cycle early so the data is held past the write strobe.
            if (we_q && cnt == CW'(1)) begin
              SRAM_WE_N <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign SRAM_DQ = dq_oe ? dq_out : {DW{1'bz}};

endmodule

// File: tb/tb_sram_arbiter_rr.sv
// tb/tb_sram_arbiter_rr.sv - scoreboard bench for sram_arbiter_rr with behavioural SRAM and arbitration model
`timescale 1ns/1ps
module tb_sram_arbiter_rr;
  localparam int NUM_CH = 4;
  localparam int AW     = 18;
  localparam int DW     = 16;
  localparam int AC     = 2;

  logic                 CLOCK_50 = 1'b0;
  logic                 RESET_N;
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    req_we;
  logic [AW-1:0]        p_addr  [NUM_CH];
  logic [DW-1:0]        p_wdata [NUM_CH];
  logic [1:0]           p_be    [NUM_CH];
  logic [NUM_CH*AW-1:0] req_addr;
  logic [NUM_CH*DW-1:0] req_wdata;
  logic [NUM_CH*2-1:0]  req_be;
  logic [NUM_CH-1:0]    gnt;
  logic [NUM_CH-1:0]    rvalid;
  logic [DW-1:0]        rdata;
  logic                 busy;
  logic [AW-1:0]        SRAM_ADDR;
  wire  [DW-1:0]        SRAM_DQ;
  logic                 SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*DW +: DW] = p_wdata[i];
      req_be[i*2 +: 2]      = p_be[i];
    end
  end

  sram_arbiter_rr #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW), .ACCESS_CYC(AC)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .busy     (busy),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N),
    .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N),
    .SRAM_CE_N(SRAM_CE_N)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int unsigned info);
    n_vec++;
    n_bad++;
    $display("FAIL %s: actual event missing/unexpected, detail %0h at %0t", name, info, $time);
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  // Behavioural SRAM: writes lanes while CE/WE are low, drives the full word while reading.
  logic [15:0] sram_mem [int];
  logic [15:0] sram_q = '0;
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_q : 16'hzzzz;

  always @(negedge CLOCK_50) begin
    logic [15:0] w;
    if (!RESET_N) begin
      sram_mem.delete();
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      w = sram_mem.exists(int'(SRAM_ADDR)) ? sram_mem[int'(SRAM_ADDR)] : 16'h0;
      if (!SRAM_LB_N) w[7:0]  = SRAM_DQ[7:0];
      if (!SRAM_UB_N) w[15:8] = SRAM_DQ[15:8];
      sram_mem[int'(SRAM_ADDR)] = w;
    end
    sram_q = sram_mem.exists(int'(SRAM_ADDR)) ? sram_mem[int'(SRAM_ADDR)] : 16'h0;
  end

  // Reference model: the bus is free every AC+1 cycles; the winner is the next
  // requesting channel after the previous winner; memory is a plain array.
  typedef struct {
    int          ch;
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_g[$];
  exp_t        exp_r[$];
  logic [15:0] ref_mem [int];
  int          cyc    = 0;
  int          m_wait = 0;
  int          m_last = NUM_CH - 1;

  always @(posedge CLOCK_50) begin
    int          w;
    int          a;
    bit          found;
    exp_t        e;
    logic [15:0] m;
    logic [15:0] old;
    cyc++;
    if (!RESET_N) begin
      m_wait = 0;
      m_last = NUM_CH - 1;
      exp_g.delete();
      exp_r.delete();
      ref_mem.delete();
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (req != '0) begin
      found = 0;
      w     = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
        if (!found && req[(m_last + k) % NUM_CH]) begin
          found = 1;
          w     = (m_last + k) % NUM_CH;
        end
      end
      m_last = w;
      m_wait = AC;
      e.ch   = w;
      e.cyc  = cyc;
      e.data = '0;
      exp_g.push_back(e);
      a   = int'(p_addr[w]);
      m   = lane_mask(p_be[w]);
      old = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
      if (req_we[w]) begin
        ref_mem[a] = (old & ~m) | (p_wdata[w] & m);
      end else begin
        e.cyc  = cyc + AC;
        e.data = old & m;
        exp_r.push_back(e);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a grant or read data.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (RESET_N) begin
      while (exp_g.size() > 0 && exp_g[0].cyc < cyc) begin
        fail_now("gnt_missing", exp_g[0].ch);
        void'(exp_g.pop_front());
      end
      while (exp_r.size() > 0 && exp_r[0].cyc < cyc) begin
        fail_now("rvalid_missing", exp_r[0].ch);
        void'(exp_r.pop_front());
      end
      if (gnt != '0) begin
        if (exp_g.size() == 0) begin
          fail_now("gnt_unexpected", gnt);
        end else begin
          e = exp_g.pop_front();
          check("gnt_vec", gnt, 1 << e.ch);
          check("gnt_cycle", cyc, e.cyc);
        end
      end
      if (rvalid != '0) begin
        if (exp_r.size() == 0) begin
          fail_now("rvalid_unexpected", rvalid);
        end else begin
          e = exp_r.pop_front();
          check("rvalid_vec", rvalid, 1 << e.ch);
          check("rvalid_cycle", cyc, e.cyc);
          check("rdata", rdata, e.data);
        end
      end
      check("busy", busy, (m_wait > 0) ? 1 : 0);
    end
  end

  // Random requesters: hold payload until granted, sometimes withdraw early.
  bit rand_en = 0;

  always @(negedge CLOCK_50) begin
    if (rand_en && RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt[i] || !req[i]) begin
          if ((gnt[i] && $urandom_range(2) == 0) || (!gnt[i] && $urandom_range(3) == 0)) begin
            req[i]     = 1'b1;
            req_we[i]  = 1'($urandom_range(1));
            p_addr[i]  = AW'($urandom_range(15));
            p_wdata[i] = 16'($urandom);
            p_be[i]    = 2'($urandom_range(3));
          end else begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(39) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  end

  task automatic access(input int ch, input logic we, input logic [AW-1:0] a,
                        input logic [15:0] d, input logic [1:0] be, output logic [15:0] rd);
    int t;
    int we_low;
    int oe_low;
    int rv_at;
    rd = '0;
    @(negedge CLOCK_50);
    req[ch] = 1'b1; req_we[ch] = we; p_addr[ch] = a; p_wdata[ch] = d; p_be[ch] = be;
    t = 0;
    while (!gnt[ch] && t < 100) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (!gnt[ch]) begin
      fail_now("gnt_timeout", ch);
      req[ch] = 1'b0;
      return;
    end
    req[ch] = 1'b0;
    we_low = 0; oe_low = 0; rv_at = -1;
    for (int i = 0; i <= AC + 1; i++) begin
      if (i > 0) @(negedge CLOCK_50);
      if (!SRAM_WE_N) we_low++;
      if (!SRAM_OE_N) oe_low++;
      if (rvalid[ch] && rv_at < 0) begin
        rv_at = i + 1;
        rd    = rdata;
      end
    end
    check("we_low_cycles", we_low, we ? AC - 1 : 0);
    check("oe_low_cycles", oe_low, we ? 0 : AC);
    if (!we) check("rd_latency", rv_at, AC + 1);
  endtask

  task automatic apply_reset();
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    req     = '0;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [15:0] rd;
    int          t;
    int          cnt;
    int          last_cyc;
    RESET_N = 1'b0;
    req     = '0;
    req_we  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      p_addr[i] = '0; p_wdata[i] = '0; p_be[i] = 2'b11;
    end

    // Reset held with every channel requesting.
    req = '1;
    repeat (3) @(negedge CLOCK_50);
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", SRAM_ADDR, 0);
    check("rst_strobes", {SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N}, 5'b11111);
    RESET_N = 1'b1;
    t = 0;
    while (gnt == '0 && t < 20) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("first_gnt", gnt, 1);
    req = '0;
    repeat (8) @(negedge CLOCK_50);

    // Single write then read on ch1.
    access(1, 1'b1, 18'h00123, 16'hBEEF, 2'b11, rd);
    access(1, 1'b0, 18'h00123, 16'h0000, 2'b11, rd);
    check("rd_beef", rd, 16'hBEEF);

    // Byte-lane writes and masked reads.
    access(0, 1'b1, 18'd5, 16'hFFFF, 2'b11, rd);
    access(0, 1'b1, 18'd5, 16'h1234, 2'b01, rd);
    access(0, 1'b0, 18'd5, 16'h0000, 2'b11, rd);
    check("be_rd_ff34", rd, 16'hFF34);
    access(0, 1'b0, 18'd5, 16'h0000, 2'b10, rd);
    check("be_rd_ff00", rd, 16'hFF00);

    // A request raised and dropped while ch0 is mid-access never gets a grant.
    @(negedge CLOCK_50);
    req[0] = 1'b1; req_we[0] = 1'b0; p_addr[0] = 18'd5; p_be[0] = 2'b11;
    t = 0;
    while (!gnt[0] && t < 50) begin
      @(negedge CLOCK_50);
      t++;
    end
    req[0] = 1'b0;
    req[2] = 1'b1; req_we[2] = 1'b0; p_addr[2] = 18'd7;
    @(negedge CLOCK_50);
    req[2] = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (gnt[2]) cnt++;
    end
    check("withdrawn_gnt2", cnt, 0);

    // Round robin with every channel holding its request.
    apply_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      req_we[i] = 1'b0; p_addr[i] = AW'(i); p_be[i] = 2'b11;
    end
    req      = '1;
    last_cyc = -1;
    for (int k = 0; k < 12; k++) begin
      t = 0;
      @(negedge CLOCK_50);
      while (gnt == '0 && t < 20) begin
        @(negedge CLOCK_50);
        t++;
      end
      check("rr_order", gnt, 1 << (k % NUM_CH));
      if (last_cyc >= 0) check("rr_spacing", cyc - last_cyc, AC + 1);
      last_cyc = cyc;
    end
    req = '0;
    repeat (8) @(negedge CLOCK_50);

    // Reset during the write strobe releases the strobes without a clock edge.
    @(negedge CLOCK_50);
    req[3] = 1'b1; req_we[3] = 1'b1; p_addr[3] = 18'd9; p_wdata[3] = 16'hA5A5; p_be[3] = 2'b11;
    t = 0;
    while (SRAM_WE_N && t < 50) begin
      @(negedge CLOCK_50);
      t++;
    end
    req[3] = 1'b0;
    check("mid_we_low_seen", SRAM_WE_N, 0);
    #2;
    RESET_N = 1'b0;
    #1;
    check("mid_rst_we_n", SRAM_WE_N, 1);
    check("mid_rst_ce_n", SRAM_CE_N, 1);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (gnt != '0 || rvalid != '0) cnt++;
    end
    check("mid_rst_quiet", cnt, 0);

    // Randomised traffic against the scoreboard.
    rand_en = 1;
    repeat (3000) @(negedge CLOCK_50);
    rand_en = 0;
    @(negedge CLOCK_50);
    req = '0;
    repeat (20) @(negedge CLOCK_50);
    check("drain_gnt", exp_g.size(), 0);
    check("drain_rvalid", exp_r.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
